mac_tx_frame: RTL

Parametrised RMII Ethernet transmitter that builds and serialises one complete Ethernet II frame per `start` request. The frame consists of preamble, SFD, destination and source MAC, EtherType, a payload taken from a `DATA_WIDTH`-bit input, zero padding to the 46-byte minimum, and a computed FCS. After each frame it enforces the inter-frame gap. It drives the RMII TX pins directly and sits in front of the existing `ether`/`bitorder`/`firewall`/`aggregate`/`cksum` receive pipeline. It is the generalised successor to the fixed 16-bit `mac_tx`.

---
 rtl/mac_tx_pkg.sv | 15 +
 rtl/crc32_dibit.sv | 17 +
 rtl/mac_tx_frame.sv | 107 ++++++++++
 3 files changed

// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: frame states, Ethernet framing constants and a CRC32 bit step for the RMII transmitter
package mac_tx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG} mac_tx_state_t;
  localparam int PREAMBLE_DIBITS = 28;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int MIN_PAYLOAD_BYTES = 46;
  localparam int HEADER_BYTES = 14;
  localparam int FCS_BYTES = 4;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  function automatic logic [31:0] crc32_bit(input logic [31:0] c, input logic b);
    return (c >> 1) ^ (CRC32_POLY_REFLECTED & {32{c[0] ^ b}});
  endfunction
endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit: reflected CRC32 register advanced two bits per clock, dibit[0] first
module crc32_dibit
  import mac_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= CRC32_INIT;
    else if (clear) crc <= CRC32_INIT;
    else if (en) crc <= crc32_bit(crc32_bit(crc, dibit[0]), dibit[1]);
  end
endmodule

// File: rtl/mac_tx_frame.sv
// mac_tx_frame: serialises one Ethernet II frame per start onto RMII TX, then holds the inter-frame gap
module mac_tx_frame
  import mac_tx_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0000_0000_0000,
  parameter logic [15:0] ETHERTYPE  = 16'h1234,
  parameter int          IFG_CYCLES = 48
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  start,
  output logic                  txen,
  output logic [1:0]            txd,
  output logic                  busy,
  output logic                  done
);
  localparam int PAYLOAD_BYTES = DATA_WIDTH / 8;
  localparam int PAD_BYTES = PAYLOAD_BYTES < MIN_PAYLOAD_BYTES ? MIN_PAYLOAD_BYTES - PAYLOAD_BYTES : 0;
  localparam logic [8*HEADER_BYTES-1:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};
  mac_tx_state_t state, ns;
  logic [15:0] cnt, nc, last;
  logic [1:0] dib, nd;
  logic [5:0] dibs;
  logic [7:0] nbyte;
  logic [DATA_WIDTH-1:0] shreg;
  logic [31:0] crc;
  logic tx_act, accept, cov;
  assign accept = state == IDLE && start;
  assign tx_act = state != IDLE && state != IFG;
  assign last = state == PREAMBLE ? 16'(PREAMBLE_DIBITS / 4 - 1) :
                state == HEADER   ? 16'(HEADER_BYTES - 1) :
                state == PAYLOAD  ? 16'(PAYLOAD_BYTES - 1) :
                state == PAD      ? 16'(PAD_BYTES - 1) :
                state == FCS      ? 16'(FCS_BYTES - 1) : 16'd0;
  assign ns = (!tx_act || cnt != last) ? state :
              state == PREAMBLE ? SFD :
              state == SFD      ? HEADER :
              state == HEADER   ? PAYLOAD :
              state == FCS      ? IFG :
              (state == PAYLOAD && PAD_BYTES > 0) ? PAD : FCS;
  assign nc = cnt == last ? 16'd0 : cnt + 16'd1;
  // the byte loaded next is chosen by the position it belongs to; FCS reads the finished CRC
  assign nbyte = ns == PREAMBLE ? PREAMBLE_BYTE :
                 ns == SFD      ? SFD_BYTE :
                 ns == HEADER   ? 8'(HDR >> {4'(HEADER_BYTES - 1) - nc[3:0], 3'b000}) :
                 ns == PAYLOAD  ? shreg[DATA_WIDTH-1 -: 8] :
                 ns == FCS      ? 8'(~crc >> {nc[1:0], 3'b000}) : 8'h00;
  assign nd = dib == 2'd3 ? nbyte[1:0] : dibs[1:0];
  // the CRC absorbs each dibit on the same edge it is registered onto txd
  assign cov = (dib == 2'd3 ? ns : state) inside {HEADER, PAYLOAD, PAD};
  crc32_dibit u_crc (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept),
    .en(tx_act && cov),
    .dibit(nd),
    .crc(crc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dib <= '0;
      dibs <= '0;
      shreg <= '0;
      txen <= 1'b0;
      txd <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state == IDLE) begin
      busy <= start;
      txen <= start;
      txd <= start ? PREAMBLE_BYTE[1:0] : 2'b00;
      done <= 1'b0;
      if (start) begin
        state <= PREAMBLE;
        cnt <= '0;
        dib <= '0;
        dibs <= PREAMBLE_BYTE[7:2];
        shreg <= data;
      end
    end else if (state == IFG) begin
      done <= 1'b0;
      cnt <= cnt + 16'd1;
      if (cnt == 16'(IFG_CYCLES - 1)) begin
        state <= IDLE;
        busy <= start;
      end
    end else begin
      dib <= dib + 2'd1;
      txd <= nd;
      dibs <= dib == 2'd3 ? nbyte[7:2] : dibs >> 2;
      if (dib == 2'd3) begin
        state <= ns;
        cnt <= nc;
        if (ns == PAYLOAD) shreg <= shreg << 8;
        if (ns == IFG) begin
          txen <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
